// File: rtl/bcd_counter_pkg.sv
// -----------------------------------------------------------------------------
// bcd_counter_pkg
// Shared constants and helper functions for the packed-BCD up/down counter.
//   BCD_DIGIT_W    : width of one BCD digit
//   BCD_NINE       : largest legal BCD digit value
//   bcd_valid      : 1 when a nibble holds a legal BCD digit (0..9)
//   bcd_all_nines  : packed all-nines word for n digits (n <= 8), zero-padded
//   bcd_step_digit : next value of a single digit stepping up or down,
//                    wrapping 9->0 (up) and 0->9 (down)
// -----------------------------------------------------------------------------
package bcd_counter_pkg;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_NINE    = 4'h9;

    function automatic logic bcd_valid(input logic [BCD_DIGIT_W-1:0] digit);
        return (digit <= BCD_NINE);
    endfunction

    function automatic logic [31:0] bcd_all_nines(input int n);
        logic [31:0] r_word;
        r_word = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < n) begin
                r_word[i*BCD_DIGIT_W +: BCD_DIGIT_W] = BCD_NINE;
            end
        end
        return r_word;
    endfunction

    function automatic logic [BCD_DIGIT_W-1:0] bcd_step_digit(
        input logic [BCD_DIGIT_W-1:0] digit,
        input logic                   up
    );
        if (up) begin
            return (digit == BCD_NINE) ? 4'h0 : digit + 4'h1;
        end
        return (digit == 4'h0) ? BCD_NINE : digit - 4'h1;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// One packed-BCD digit register. Load has priority over step; a step moves
// the digit by one in the direction given by i_up_dn, wrapping 9->0 / 0->9.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset, clears the digit
//   i_load     : load i_load_val on the next edge
//   i_load_val : digit value to load (caller guarantees it is legal BCD)
//   i_step     : step the digit one position on the next edge
//   i_up_dn    : 1 = step up, 0 = step down
//   o_digit    : current digit value
//   o_at_nine  : digit currently equals 9 (carry condition for next digit)
//   o_at_zero  : digit currently equals 0 (borrow condition for next digit)
// -----------------------------------------------------------------------------
module bcd_digit
    import bcd_counter_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_load,
    input  logic [BCD_DIGIT_W-1:0] i_load_val,
    input  logic                   i_step,
    input  logic                   i_up_dn,
    output logic [BCD_DIGIT_W-1:0] o_digit,
    output logic                   o_at_nine,
    output logic                   o_at_zero
);

    logic [BCD_DIGIT_W-1:0] r_digit;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_digit <= '0;
        end else if (i_load) begin
            r_digit <= i_load_val;
        end else if (i_step) begin
            r_digit <= bcd_step_digit(r_digit, i_up_dn);
        end
    end

    assign o_digit   = r_digit;
    assign o_at_nine = (r_digit == BCD_NINE);
    assign o_at_zero = (r_digit == '0);

endmodule

// File: rtl/bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// bcd_updown_counter
// N-digit packed-BCD up/down counter with synchronous parallel load and a
// programmable upper limit (MAX_BCD) for modulo counting.
// Build option: define BCD_COUNTER_SAT_EN for saturating mode (hold at the
// limit, tc pulses once on arrival). Default build wraps at the limit.
// Parameters:
//   N        : number of BCD digits (1..8)
//   MAX_BCD  : upper count limit, packed BCD, must be a legal BCD value
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   clk_en   : count enable, one step per cycle
//   up_dn    : 1 = count up, 0 = count down
//   load     : synchronous parallel load request (beats clk_en)
//   load_val : packed BCD load value
//   sal      : current count, digit 0 in sal[3:0]
//   tc       : registered terminal-count strobe
//   load_err : registered strobe for a rejected load
//   at_limit : combinational, sal at the limit for the current direction
// -----------------------------------------------------------------------------
module bcd_updown_counter
    import bcd_counter_pkg::*;
#(
    parameter int               N       = 3,
    parameter logic [4*N-1:0]   MAX_BCD = (4*N)'(bcd_all_nines(N))
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clk_en,
    input  logic           up_dn,
    input  logic           load,
    input  logic [4*N-1:0] load_val,
    output logic [4*N-1:0] sal,
    output logic           tc,
    output logic           load_err,
    output logic           at_limit
);

    localparam int W = BCD_DIGIT_W * N;

    logic [W-1:0] w_sal;
    logic [N-1:0] w_at_nine;
    logic [N-1:0] w_at_zero;
    logic [N-1:0] w_step;
    logic [W-1:0] w_limit;
    logic         w_at_limit;
    logic         w_load_ok;
    logic         w_count;
    logic         w_dig_load;
    logic [W-1:0] w_dig_load_val;
    logic         w_tc_next;
    logic         r_tc;
    logic         r_load_err;

    // The limit depends on direction: MAX_BCD going up, zero going down.
    assign w_limit    = up_dn ? MAX_BCD : '0;
    assign w_at_limit = (w_sal == w_limit);

    // Packed BCD preserves numeric order, so a plain binary compare against
    // MAX_BCD is valid once every digit is known to be legal.
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        w_load_ok = (load_val <= MAX_BCD);
        for (int i = 0; i < N; i++) begin
            if (!bcd_valid(load_val[i*BCD_DIGIT_W +: BCD_DIGIT_W])) begin
                w_load_ok = 1'b0;
            end
        end
    end

    // Ordinary in-range step; the limit case is handled as a whole-word event.
    assign w_count = clk_en & ~load & ~w_at_limit;

    // Ripple carry/borrow: digit i steps when all lower digits are at 9 (up)
    // or at 0 (down).
    always_comb begin
        w_step    = '0;
        w_step[0] = w_count;
        for (int i = 1; i < N; i++) begin
            w_step[i] = w_step[i-1] & (up_dn ? w_at_nine[i-1] : w_at_zero[i-1]);
        end
    end

`ifdef BCD_COUNTER_SAT_EN
    logic [W-1:0] w_next;

    // Predicted post-step word, used only to flag arrival at the limit.
    always_comb begin
        w_next = w_sal;
        for (int i = 0; i < N; i++) begin
            if (w_step[i]) begin
                w_next[i*BCD_DIGIT_W +: BCD_DIGIT_W] =
                    bcd_step_digit(w_sal[i*BCD_DIGIT_W +: BCD_DIGIT_W], up_dn);
            end
        end
    end

    // At the limit the counter simply holds; only real loads touch digits.
    assign w_dig_load     = load & w_load_ok;
    assign w_dig_load_val = load_val;
    assign w_tc_next      = w_count & (w_next == w_limit);
`else
    logic w_wrap;

    // Wrapping is a parallel load of the opposite end of the range.
    assign w_wrap         = clk_en & ~load & w_at_limit;
    assign w_dig_load     = (load & w_load_ok) | w_wrap;
    assign w_dig_load_val = load ? load_val : (up_dn ? '0 : MAX_BCD);
    assign w_tc_next      = w_wrap;
`endif

    for (genvar g = 0; g < N; g++) begin : g_digit
        bcd_digit u_digit (
            .clk        (clk),
            .rst        (rst),
            .i_load     (w_dig_load),
            .i_load_val (w_dig_load_val[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .i_step     (w_step[g]),
            .i_up_dn    (up_dn),
            .o_digit    (w_sal[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_at_nine  (w_at_nine[g]),
            .o_at_zero  (w_at_zero[g])
        );
    end

    // Strobes are registered so they line up with the sal update they report.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tc       <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_tc       <= w_tc_next;
            r_load_err <= load & ~w_load_ok;
        end
    end

    assign sal      = w_sal;
    assign tc       = r_tc;
    assign load_err = r_load_err;
    assign at_limit = w_at_limit;

endmodule
